// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter for the register file write port (WB/IRQ/DBG) with debug lock; optional grant counters via REG_WRITE_ARB_STATS_EN
module reg_write_arbiter #(
  parameter int NUM_REGS = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic              wb_we,
  input  logic [3:0]        wb_index,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_t_we,
  input  logic              wb_t_data,
  input  logic              irq_valid,
  output logic              irq_ready,
  input  logic [3:0]        irq_index,
  input  logic [DATA_W-1:0] irq_data,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic [3:0]        dbg_index,
  input  logic [DATA_W-1:0] dbg_data,
  input  logic              dbg_lock,
`ifdef REG_WRITE_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       wb_grants,
  output logic [15:0]       irq_grants,
  output logic [15:0]       dbg_grants,
`endif
  output logic              rf_write_en,
  output logic [3:0]        rf_write_index,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_t_we_n,
  output logic              rf_t_data,
  output logic              bad_index,
  output logic              locked
);
  typedef enum logic {IDLE, LOCKED} state_t;
  localparam logic [4:0] NR = 5'(NUM_REGS);
  state_t state;
  logic [1:0] ptr;
  logic [2:0] req, gnt;
  logic [3:0] sel_index;
  logic [DATA_W-1:0] sel_data;
  logic any, gpr, idx_ok;
  assign req = {dbg_valid, irq_valid, wb_valid};
  // Grant: only DBG while locked, otherwise first valid requester scanning from the pointer
  always_comb begin
    gnt = 3'b000;
    if (state == LOCKED) gnt = {dbg_valid, 2'b00};
    else if (ptr == 2'd0) gnt = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
    else if (ptr == 2'd1) gnt = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
    else gnt = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
  end
  assign {dbg_ready, irq_ready, wb_ready} = gnt;
  assign any = |gnt;
  assign sel_index = gnt[0] ? wb_index : gnt[1] ? irq_index : dbg_index;
  assign sel_data = gnt[0] ? wb_data : gnt[1] ? irq_data : dbg_data;
  assign gpr = gnt[0] ? wb_we : 1'b1;
  assign idx_ok = {1'b0, sel_index} < NR;
  assign locked = state == LOCKED;
  // Registered write port outputs, lock state and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 2'd0;
      rf_write_en <= 1'b0;
      rf_write_index <= '0;
      rf_write_data <= '0;
      rf_t_we_n <= 1'b1;
      rf_t_data <= 1'b0;
      bad_index <= 1'b0;
    end else begin
      rf_write_en <= any & gpr & idx_ok;
      bad_index <= any & gpr & ~idx_ok;
      rf_t_we_n <= ~(gnt[0] & wb_t_we & (idx_ok | ~wb_we));
      if (any) begin
        rf_write_index <= sel_index;
        rf_write_data <= sel_data;
      end
      if (gnt[0]) rf_t_data <= wb_t_data;
      if (state == IDLE) begin
        if (any) ptr <= gnt[0] ? 2'd1 : gnt[1] ? 2'd2 : 2'd0;
        if (gnt[2] & dbg_lock) state <= LOCKED;
      end else if (!dbg_lock) begin
        state <= IDLE;
        ptr <= 2'd0;
      end
    end
  end
`ifdef REG_WRITE_ARB_STATS_EN
  // Saturating per-requester grant counters; clear wins over a same-cycle grant
  always_ff @(posedge clk) begin
    if (rst | stats_clr) begin
      wb_grants <= '0;
      irq_grants <= '0;
      dbg_grants <= '0;
    end else begin
      if (gnt[0] && wb_grants != 16'hFFFF) wb_grants <= wb_grants + 16'd1;
      if (gnt[1] && irq_grants != 16'hFFFF) irq_grants <= irq_grants + 16'd1;
      if (gnt[2] && dbg_grants != 16'hFFFF) dbg_grants <= dbg_grants + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed and randomized checks of reg_write_arbiter against a behavioural model
module tb_reg_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic wb_valid = 0, wb_ready, wb_we = 0, wb_t_we = 0, wb_t_data = 0;
  logic [3:0] wb_index = 0, irq_index = 0, dbg_index = 0;
  logic [15:0] wb_data = 0, irq_data = 0, dbg_data = 0;
  logic irq_valid = 0, irq_ready, dbg_valid = 0, dbg_ready, dbg_lock = 0;
  logic stats_clr = 0;
  logic [15:0] wb_grants, irq_grants, dbg_grants;
  logic rf_write_en, rf_t_we_n, rf_t_data, bad_index, locked;
  logic [3:0] rf_write_index;
  logic [15:0] rf_write_data;

  reg_write_arbiter dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_index(wb_index),
    .wb_data(wb_data), .wb_t_we(wb_t_we), .wb_t_data(wb_t_data),
    .irq_valid(irq_valid), .irq_ready(irq_ready), .irq_index(irq_index), .irq_data(irq_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_index(dbg_index), .dbg_data(dbg_data),
    .dbg_lock(dbg_lock),
`ifdef REG_WRITE_ARB_STATS_EN
    .stats_clr(stats_clr), .wb_grants(wb_grants), .irq_grants(irq_grants), .dbg_grants(dbg_grants),
`endif
    .rf_write_en(rf_write_en), .rf_write_index(rf_write_index), .rf_write_data(rf_write_data),
    .rf_t_we_n(rf_t_we_n), .rf_t_data(rf_t_data), .bad_index(bad_index), .locked(locked)
  );

  int checks = 0, failures = 0;
  bit m_lock = 0;
  int m_ptr = 0;
  int cnt[3] = '{0, 0, 0};
  logic e_we = 0, e_tn = 1, e_t = 0, e_bad = 0;
  logic [3:0] e_idx = 0;
  logic [15:0] e_data = 0;
  logic [2:0] mg, rdy_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    logic [2:0] v;
    v = {dbg_valid, irq_valid, wb_valid};
    if (m_lock) return dbg_valid ? 2 : -1;
    for (int k = 0; k < 3; k++) if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  task automatic step();
    int g;
    logic [3:0] ix;
    logic ok, gp;
    #1;
    g = pick();
    mg = (g < 0) ? 3'b000 : 3'(1 << g);
    rdy_seen = {dbg_ready, irq_ready, wb_ready};
    check("ready", 32'(rdy_seen), 32'(mg));
    if (rst) begin
      m_lock = 0; m_ptr = 0;
      e_we = 0; e_tn = 1; e_t = 0; e_bad = 0; e_idx = 0; e_data = 0;
      cnt = '{0, 0, 0};
    end else begin
      if (g >= 0) begin
        ix = (g == 0) ? wb_index : (g == 1) ? irq_index : dbg_index;
        gp = (g == 0) ? wb_we : 1'b1;
        ok = ix < 4'd11;
        e_we = gp & ok;
        e_bad = gp & ~ok;
        e_tn = !(g == 0 && wb_t_we && (ok || !wb_we));
        e_idx = ix;
        e_data = (g == 0) ? wb_data : (g == 1) ? irq_data : dbg_data;
        if (g == 0) e_t = wb_t_data;
        if (!stats_clr && cnt[g] != 65535) cnt[g]++;
      end else begin
        e_we = 0; e_bad = 0; e_tn = 1;
      end
      if (stats_clr) cnt = '{0, 0, 0};
      if (!m_lock) begin
        if (g >= 0) m_ptr = (g + 1) % 3;
        if (g == 2 && dbg_lock) m_lock = 1;
      end else if (!dbg_lock) begin
        m_lock = 0; m_ptr = 0;
      end
    end
    @(posedge clk);
    #1;
    check("write_en", 32'(rf_write_en), 32'(e_we));
    check("bad_index", 32'(bad_index), 32'(e_bad));
    check("t_we_n", 32'(rf_t_we_n), 32'(e_tn));
    check("locked", 32'(locked), 32'(m_lock));
    if (e_we) begin
      check("write_index", 32'(rf_write_index), 32'(e_idx));
      check("write_data", 32'(rf_write_data), 32'(e_data));
    end
    if (!e_tn) check("t_data", 32'(rf_t_data), 32'(e_t));
`ifdef REG_WRITE_ARB_STATS_EN
    check("wb_grants", 32'(wb_grants), 32'(cnt[0]));
    check("irq_grants", 32'(irq_grants), 32'(cnt[1]));
    check("dbg_grants", 32'(dbg_grants), 32'(cnt[2]));
`endif
  endtask

  initial begin
    #1;
    step();
    step();
    rst = 0;
    check("rst_write_en", 32'(rf_write_en), 32'd0);
    check("rst_t_we_n", 32'(rf_t_we_n), 32'd1);
    check("rst_index", 32'(rf_write_index), 32'd0);
    check("rst_data", 32'(rf_write_data), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    // basic WB write with T
    wb_valid = 1; wb_we = 1; wb_index = 3; wb_data = 16'h1234; wb_t_we = 1; wb_t_data = 1;
    step();
    wb_valid = 0;
    check("wb1_en", 32'(rf_write_en), 32'd1);
    check("wb1_idx", 32'(rf_write_index), 32'd3);
    check("wb1_data", 32'(rf_write_data), 32'h1234);
    check("wb1_tn", 32'(rf_t_we_n), 32'd0);
    check("wb1_t", 32'(rf_t_data), 32'd1);
    // DBG alone moves pointer back to WB
    dbg_valid = 1; dbg_index = 5; dbg_data = 16'h0055; dbg_lock = 0;
    step();
    // all three valid: WB, IRQ, DBG order
    wb_valid = 1; wb_index = 4; wb_data = 16'hAAAA; wb_t_we = 0;
    irq_valid = 1; irq_index = 9; irq_data = 16'hBBBB;
    dbg_index = 6; dbg_data = 16'hCCCC;
    step(); check("rr0", 32'(rdy_seen), 32'b001);
    step(); check("rr1", 32'(rdy_seen), 32'b010);
    step(); check("rr2", 32'(rdy_seen), 32'b100);
    wb_valid = 0; irq_valid = 0; dbg_valid = 0;
    // IRQ invalid index
    irq_valid = 1; irq_index = 12; irq_data = 16'hDEAD;
    step();
    irq_valid = 0;
    check("bad_rdy", 32'(rdy_seen), 32'b010);
    check("bad_pulse", 32'(bad_index), 32'd1);
    check("bad_en", 32'(rf_write_en), 32'd0);
    check("bad_tn", 32'(rf_t_we_n), 32'd1);
    // debug lock burst
    dbg_valid = 1; dbg_index = 1; dbg_data = 16'h0101; dbg_lock = 1;
    step();
    dbg_valid = 0;
    check("lock_on", 32'(locked), 32'd1);
    wb_valid = 1; wb_index = 2; wb_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      step();
      check("lock_wb_blk", 32'(rdy_seen), 32'b000);
      check("lock_hold", 32'(locked), 32'd1);
    end
    dbg_valid = 1; dbg_index = 2; dbg_data = 16'h0202; dbg_lock = 0;
    step();
    dbg_valid = 0;
    check("unlock_rdy", 32'(rdy_seen), 32'b100);
    check("unlock", 32'(locked), 32'd0);
    step();
    check("after_unlock_wb", 32'(rdy_seen), 32'b001);
    wb_valid = 0;
    // reset right after a locking transfer
    dbg_valid = 1; dbg_index = 7; dbg_data = 16'h0707; dbg_lock = 1;
    step();
    dbg_valid = 0; wb_valid = 1; rst = 1;
    step();
    rst = 0; dbg_lock = 0;
    check("rst_mid_en", 32'(rf_write_en), 32'd0);
    check("rst_mid_locked", 32'(locked), 32'd0);
    step();
    check("rst_mid_wb", 32'(rdy_seen), 32'b001);
    wb_valid = 0;
`ifdef REG_WRITE_ARB_STATS_EN
    stats_clr = 1; step(); stats_clr = 0;
    wb_valid = 1;
    for (int i = 0; i < 5; i++) step();
    check("stats5", 32'(wb_grants), 32'd5);
    stats_clr = 1; step(); stats_clr = 0;
    check("stats_clr", 32'(wb_grants), 32'd0);
    wb_valid = 0;
`endif
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (mg[0] || !wb_valid) begin
        wb_valid = $urandom_range(0, 9) < 6;
        wb_we = $urandom_range(0, 3) != 0;
        wb_index = wb_we ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 10));
        wb_data = 16'($urandom);
        wb_t_we = 1'($urandom);
        wb_t_data = 1'($urandom);
      end
      if (mg[1] || !irq_valid) begin
        irq_valid = $urandom_range(0, 9) < 4;
        irq_index = 4'($urandom_range(0, 15));
        irq_data = 16'($urandom);
      end
      if (mg[2] || !dbg_valid) begin
        dbg_valid = $urandom_range(0, 9) < 4;
        dbg_index = 4'($urandom_range(0, 15));
        dbg_data = 16'($urandom);
        dbg_lock = $urandom_range(0, 3) == 0;
      end
      rst = $urandom_range(0, 199) == 0;
      stats_clr = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 0; stats_clr = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
